audio_i2s_tx: RTL
=================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed one per line as name, direction, width, meaning, clock and reset first.
REQ-002 pclk  input  1  sole clock; all flops rise on pclk.
REQ-003 prst_n  input  1  asynchronous active-low reset.
REQ-004 i2s_enable  input  1  transmit enable from the audio register block.
REQ-005 clk_div  input  8  BCLK half-period in pclk cycles, minus 1.
REQ-006 s_valid  input  1  sample-word valid.
REQ-007 s_ready  output  1  FIFO can accept a word.
REQ-008 s_data  input  32  stereo word: left channel in [31:16], right channel in [15:0].
REQ-009 tx_empty  output  1  FIFO holds zero words; drives the register block's i2s_tx_empty.
REQ-010 underrun  output  1  one-cycle pulse when a frame starts with the FIFO empty.
REQ-011 i2s_bclk  output  1  serial bit clock.
REQ-012 i2s_lrclk  output  1  word select: 0 = left, 1 = right.
REQ-013 i2s_sdo  output  1  serial data, MSB first.

Function
REQ-014 The FIFO SHALL hold 4 words; s_ready = !full, and a word is written when s_valid && s_ready.
REQ-015 A write and a pop in the same cycle on a full FIFO SHALL both succeed, with the count unchanged and s_ready staying low that cycle.
REQ-016 tx_empty SHALL be combinational from FIFO count == 0.
REQ-017 The FSM SHALL have two states, IDLE and RUN; IDLE -> RUN when i2s_enable && !tx_empty.
REQ-018 RUN -> IDLE SHALL occur only at a frame boundary with i2s_enable low; a frame in progress always completes.
REQ-019 In IDLE the outputs SHALL hold i2s_bclk=0, i2s_lrclk=0, i2s_sdo=0, with the divider and bit counter cleared.
REQ-020 clk_div SHALL be latched on IDLE -> RUN; changes in RUN are ignored.
REQ-021 Divider: count 0..clk_div; at terminal count, toggle i2s_bclk and restart; clk_div=0 gives BCLK = pclk/2.
REQ-022 Bit slot counter b (5 bits) SHALL advance on each BCLK falling edge (the 1 -> 0 toggle) and wrap 31 -> 0.
REQ-023 All of i2s_lrclk, i2s_sdo and the counter SHALL update only on BCLK falling edges.
REQ-024 i2s_lrclk SHALL be 0 for slots 0..15 and 1 for slots 16..31.
REQ-025 Frame start is entry to slot 0; the block SHALL pop one FIFO word W into the shift register, or load 0 and pulse underrun if the FIFO is empty.
REQ-026 I2S one-bit delay: sdo in slot b (1..31) = W[32-b]; sdo in slot 0 of the next frame = W[0].
REQ-027 The first frame after IDLE SHALL drive sdo=0 in slot 0.
REQ-028 The first falling-edge event after entering RUN SHALL be treated as entry to slot 0.
REQ-029 Dropping i2s_enable SHALL NOT flush the FIFO; the remaining words are sent on the next enable.

Reset
REQ-030 While prst_n=0: FIFO empty (tx_empty=1, s_ready=1), state IDLE, i2s_bclk=0, i2s_lrclk=0, i2s_sdo=0, underrun=0, counters 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately and discard the FIFO contents.

Structure
REQ-032 A shared audio_pkg SHALL hold I2S_FIFO_DEPTH=4, I2S_SLOT_BITS=16, the FSM state enum, and the 32-bit stereo word type.
REQ-033 The FIFO SHALL be a separate sub-module, audio_sync_fifo, parameterised by width and depth.

Verification
REQ-034 Bench scenarios:
- Reset, then check all outputs -> tx_empty=1, s_ready=1, bclk/lrclk/sdo=0.
- Write 0xA5A5_3C3C, clk_div=1, enable -> bclk period 4 pclk; slots 1..16 carry 0xA5A5 MSB first; slots 17..31 plus next slot 0 carry 0x3C3C; lrclk flips at slot 16.
- Write 5 words back-to-back with enable=0 -> s_ready drops after the 4th; the 5th is not accepted until a pop.
- Enable with 1 word queued -> second frame starts empty: underrun pulses once for one pclk, sdo=0 for that frame.
- Drop enable at slot 10 -> frame completes through slot 31, then IDLE with outputs 0; the FIFO count is preserved.
- Assert prst_n low at slot 20 -> outputs 0 asynchronously, FIFO empty; re-enable with no data -> stays IDLE.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio transmit path.
package audio_pkg;
    localparam int I2S_FIFO_DEPTH  = 4;
    localparam int I2S_SLOT_BITS   = 16;
    localparam int I2S_FRAME_SLOTS = 2 * I2S_SLOT_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

    typedef struct packed {
        logic [I2S_SLOT_BITS-1:0] left;
        logic [I2S_SLOT_BITS-1:0] right;
    } stereo_word_t;
endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write on a full FIFO is taken
// when a read happens in the same cycle.
module audio_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             pclk,
    input  logic             prst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr, do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (do_rd && !do_wr) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge pclk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S stereo transmitter: 4-word sample FIFO, programmable BCLK divider and
// 32-slot frame with the standard one-bit data delay after LRCLK changes.
module audio_i2s_tx
    import audio_pkg::*;
(
    input  logic        pclk,
    input  logic        prst_n,
    input  logic        i2s_enable,
    input  logic [7:0]  clk_div,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        tx_empty,
    output logic        underrun,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdo
);
    i2s_state_e   state_q, state_d;
    logic [7:0]   div_q, cnt_q;
    logic [4:0]   slot_q, slot_nxt;
    logic         first_q;
    logic [31:0]  sr_q;
    logic         bclk_q, lrclk_q, sdo_q, underrun_q;
    logic         tick, fall, boundary, pop;
    logic         fifo_full, fifo_empty;
    stereo_word_t fifo_rd;

    audio_sync_fifo #(
        .WIDTH ($bits(stereo_word_t)),
        .DEPTH (I2S_FIFO_DEPTH)
    ) u_fifo (
        .pclk    (pclk),
        .prst_n  (prst_n),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign s_ready  = !fifo_full;
    assign tx_empty = fifo_empty;

    // A BCLK falling edge either advances the slot or, at slot 31 or the very
    // first fall after RUN entry, starts a new frame.
    assign tick     = (state_q == RUN) && (cnt_q == div_q);
    assign fall     = tick && bclk_q;
    assign boundary = fall && (first_q || slot_q == 5'(I2S_FRAME_SLOTS - 1));
    assign pop      = boundary && i2s_enable && !fifo_empty;
    assign slot_nxt = slot_q + 5'd1;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i2s_enable && !fifo_empty) state_d = RUN;
            RUN:     if (boundary && !i2s_enable)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            div_q      <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            first_q    <= 1'b1;
            sr_q       <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdo_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else if (state_q == IDLE || state_d == IDLE) begin
            cnt_q      <= '0;
            slot_q     <= '0;
            first_q    <= 1'b1;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdo_q      <= 1'b0;
            underrun_q <= 1'b0;
            if (state_d == RUN) div_q <= clk_div;
        end else begin
            underrun_q <= 1'b0;
            if (tick) begin
                cnt_q  <= '0;
                bclk_q <= ~bclk_q;
                if (boundary) begin
                    // Slot 0 carries the previous word's LSB (nothing after IDLE).
                    slot_q     <= '0;
                    lrclk_q    <= 1'b0;
                    sdo_q      <= first_q ? 1'b0 : sr_q[31];
                    sr_q       <= pop ? fifo_rd : '0;
                    underrun_q <= fifo_empty;
                    first_q    <= 1'b0;
                end else if (fall) begin
                    slot_q  <= slot_nxt;
                    lrclk_q <= slot_nxt[4];
                    sdo_q   <= sr_q[31];
                    sr_q    <= {sr_q[30:0], 1'b0};
                end
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdo   = sdo_q;
    assign underrun  = underrun_q;
endmodule
